// File: rtl/demux_1to4_sched.sv
// Round-robin burst scheduler in front of a 1-to-4 demux.
// One valid/ready input stream is handed to one sink at a time, for up to
// BURST beats per grant. A single registered data stage feeds every sink.
// The one-hot out_valid vector and the {s0,s1} select pair indicate which
// sink currently owns that stage.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no owner; choose the next eligible sink (takes one cycle)
// GRANT | stream beats to grant_q until the burst closes and drains
module demux_1to4_sched #(
  parameter int DW    = 8,
  parameter int BURST = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [3:0]    sink_en,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  input  logic          in_last,
  output logic          in_ready,
  output logic [3:0]    out_valid,
  output logic [DW-1:0] out_data,
  input  logic [3:0]    out_ready,
  output logic          s0,
  output logic          s1,
  output logic          busy
);

  localparam int CW = $clog2(BURST + 1);
  // cnt_q is the number of beats already taken. When it equals this value,
  // the beat being accepted is the final beat the burst allows.
  localparam logic [CW-1:0] CNT_LAST = CW'(BURST - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      grant_q, grant_d;
  logic [1:0]      last_grant_q, last_grant_d;
  logic            hold_v_q, hold_v_d;
  logic [DW-1:0]   data_q, data_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            closing_q, closing_d;

  logic [1:0]      pick;
  logic            pick_ok;
  logic [1:0]      scan_idx;
  logic            sel_ready;
  logic            drain_ok;
  logic            take_ok;
  logic            accept;

  // Round-robin search: the sink after the previous winner is checked first,
  // and the previous winner itself is checked last.
  always_comb begin
    pick     = 2'd0;
    pick_ok  = 1'b0;
    scan_idx = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      scan_idx = last_grant_q + 2'(i);
      if (!pick_ok && sink_en[scan_idx]) begin
        pick    = scan_idx;
        pick_ok = 1'b1;
      end
    end
  end

  // Handshake terms. Only the granted sink's ready is used. The holding
  // stage can accept a new beat when it is empty or is being emptied in
  // the same cycle.
  always_comb begin
    sel_ready = out_ready[grant_q];
    drain_ok  = !hold_v_q || sel_ready;
    take_ok   = (state_q == GRANT) && !closing_q && drain_ok;
    accept    = take_ok && in_valid;
  end

  // Next-state logic and next values for the data stage.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    hold_v_d     = hold_v_q;
    data_d       = data_q;
    cnt_d        = cnt_q;
    closing_d    = closing_q;
    case (state_q)
      IDLE: begin
        if (en && in_valid && pick_ok) begin
          grant_d   = pick;
          cnt_d     = '0;
          closing_d = 1'b0;
          state_d   = GRANT;
        end
      end
      GRANT: begin
        if (accept) begin
          data_d    = in_data;
          hold_v_d  = 1'b1;
          cnt_d     = cnt_q + 1'b1;
          closing_d = in_last || (cnt_q == CNT_LAST);
        end else if (hold_v_q && sel_ready) begin
          hold_v_d = 1'b0;
        end
        // While the burst is closing, no new beat is taken. This cycle
        // therefore only empties the holding stage and then releases the
        // grant.
        if (closing_q && drain_ok) begin
          last_grant_d = grant_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and data registers. last_grant resets to 3 so that sink 0 is the
  // first sink checked after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= 2'd0;
      last_grant_q <= 2'd3;
      hold_v_q     <= 1'b0;
      data_q       <= '0;
      cnt_q        <= '0;
      closing_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      hold_v_q     <= hold_v_d;
      data_q       <= data_d;
      cnt_q        <= cnt_d;
      closing_q    <= closing_d;
    end
  end

  // Output decode. grant_q stays fixed for the whole GRANT state, so the
  // select pair does not move while the last beat drains.
  always_comb begin
    in_ready  = take_ok;
    out_valid = hold_v_q ? (4'b0001 << grant_q) : 4'b0000;
    out_data  = data_q;
    s0        = grant_q[1];
    s1        = grant_q[0];
    busy      = (state_q == GRANT);
  end

endmodule

// File: tb/tb_demux_1to4_sched.sv
// Bench for demux_1to4_sched: directed scenarios plus a randomized run,
// scored against a grant-level model of the scheduling rules.
module tb_demux_1to4_sched;

  localparam int DW    = 8;
  localparam int BURST = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [3:0]    sink_en;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          in_ready;
  logic [3:0]    out_valid;
  logic [DW-1:0] out_data;
  logic [3:0]    out_ready;
  logic          s0;
  logic          s1;
  logic          busy;

  demux_1to4_sched #(.DW(DW), .BURST(BURST)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sink_en(sink_en),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .s0(s0), .s1(s1), .busy(busy)
  );

  // Free-running clock with a 10 ns period.
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Grant-level reference model state.
  int m_last;
  bit m_open;
  int m_cnt;
  int m_sink;

  int exp_data_q[$];
  int exp_sink_q[$];
  int acc_cyc_q[$];
  int obs_data_q[$];
  int obs_sink_q[$];
  int dlv_cyc_q[$];
  int grant_obs_q[$];

  int            cyc;
  bit            acc_flag;
  bit            busy_prev;
  int            sel_err;
  logic          s_in_ready;
  logic [3:0]    s_out_valid;
  logic [DW-1:0] s_out_data;
  logic [1:0]    s_sel;
  logic          s_busy;

  function automatic int next_sink(int last, logic [3:0] mask);
    for (int i = 1; i <= 4; i++) begin
      int k;
      k = (last + i) % 4;
      if (mask[k]) return k;
    end
    return -1;
  endfunction

  task automatic clear_queues();
    exp_data_q.delete(); exp_sink_q.delete(); acc_cyc_q.delete();
    obs_data_q.delete(); obs_sink_q.delete(); dlv_cyc_q.delete();
    grant_obs_q.delete();
    sel_err = 0;
  endtask

  task automatic clear_model();
    m_last = 3; m_open = 0; m_cnt = 0; m_sink = 0;
    busy_prev = 0; cyc = 0;
    clear_queues();
  endtask

  // One clock cycle: sample the DUT 1 ns after inputs settle, update the
  // model with the handshakes that happen at the coming edge, then move to
  // the next negedge.
  task automatic tick();
    #1;
    s_in_ready  = in_ready;
    s_out_valid = out_valid;
    s_out_data  = out_data;
    s_sel       = {s0, s1};
    s_busy      = busy;
    acc_flag    = in_valid && s_in_ready;
    if (s_busy && !busy_prev) grant_obs_q.push_back(int'(s_sel));
    busy_prev = s_busy;
    if (s_out_valid != 4'b0000 && s_out_valid != (4'b0001 << s_sel)) sel_err++;
    if (acc_flag) begin
      if (!m_open) begin
        m_sink = next_sink(m_last, sink_en);
        m_open = 1;
        m_cnt  = 0;
      end
      exp_data_q.push_back(int'(in_data));
      exp_sink_q.push_back(m_sink);
      acc_cyc_q.push_back(cyc);
      m_cnt++;
      if (in_last || m_cnt == BURST) begin
        m_open = 0;
        m_last = m_sink;
      end
    end
    for (int k = 0; k < 4; k++) begin
      if (s_out_valid[k] && out_ready[k]) begin
        obs_data_q.push_back(int'(s_out_data));
        obs_sink_q.push_back(k);
        dlv_cyc_q.push_back(cyc);
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_data = '0; out_ready = 4'b0000; sink_en = 4'b0000;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst_n = 1'b1;
    clear_model();
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
    checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL reset_out_valid got %b exp 0000", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if ({s0, s1} !== 2'b00) begin errors++; $display("FAIL reset_sel got %b exp 00", {s0, s1}); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got %h exp 00", out_data); end
    en = 1'b0; sink_en = 4'b1111; in_valid = 1'b1; in_data = 8'hAA; out_ready = 4'b1111;
    repeat (4) tick();
    checks++; if (grant_obs_q.size() !== 0 || acc_cyc_q.size() !== 0) begin
      errors++; $display("FAIL reset_en0_grant got grants=%0d accepts=%0d exp 0 0", grant_obs_q.size(), acc_cyc_q.size());
    end
  endtask

  task automatic test_basic();
    int n;
    int idle_cnt;
    do_reset();
    en = 1'b1; sink_en = 4'b1111; out_ready = 4'b1111; in_last = 1'b0;
    n = 0; idle_cnt = 0;
    for (int c = 0; c < 60 && obs_data_q.size() < 8; c++) begin
      in_valid = (n < 8);
      in_data  = DW'(n + 1);
      tick();
      if (n >= 1 && n < 8 && !s_busy) idle_cnt++;
      if (acc_flag) n++;
    end
    in_valid = 1'b0;
    checks++; if (obs_data_q.size() !== 8) begin errors++; $display("FAIL basic_count got %0d exp 8", obs_data_q.size()); end
    for (int i = 0; i < 8 && i < obs_data_q.size() && i < acc_cyc_q.size(); i++) begin
      checks++; if (obs_data_q[i] !== i + 1) begin errors++; $display("FAIL basic_data[%0d] got %0h exp %0h", i, obs_data_q[i], i + 1); end
      checks++; if (obs_sink_q[i] !== (i < 4 ? 0 : 1)) begin errors++; $display("FAIL basic_sink[%0d] got %0d exp %0d", i, obs_sink_q[i], (i < 4 ? 0 : 1)); end
      checks++; if (dlv_cyc_q[i] !== acc_cyc_q[i] + 1) begin errors++; $display("FAIL basic_latency[%0d] got %0d exp %0d", i, dlv_cyc_q[i] - acc_cyc_q[i], 1); end
    end
    checks++; if (idle_cnt !== 1) begin errors++; $display("FAIL basic_idle_gap got %0d exp 1", idle_cnt); end
    checks++; if (grant_obs_q.size() !== 2) begin errors++; $display("FAIL basic_grants got %0d exp 2", grant_obs_q.size()); end
    checks++; if (sel_err !== 0) begin errors++; $display("FAIL basic_select got %0d bad cycles exp 0", sel_err); end
  endtask

  task automatic test_mask();
    int n;
    int bad;
    int exp_g[4] = '{0, 2, 0, 2};
    do_reset();
    en = 1'b1; sink_en = 4'b0101; out_ready = 4'b1111; in_last = 1'b0;
    n = 0; bad = 0; in_data = DW'($urandom);
    for (int c = 0; c < 80 && obs_data_q.size() < 16; c++) begin
      in_valid = (n < 16);
      tick();
      if (s_busy && s_sel[0]) bad++;
      if (acc_flag) begin n++; in_data = DW'($urandom); end
    end
    in_valid = 1'b0;
    checks++; if (grant_obs_q.size() !== 4) begin errors++; $display("FAIL mask_grants got %0d exp 4", grant_obs_q.size()); end
    for (int i = 0; i < 4 && i < grant_obs_q.size(); i++) begin
      checks++; if (grant_obs_q[i] !== exp_g[i]) begin errors++; $display("FAIL mask_order[%0d] got %0d exp %0d", i, grant_obs_q[i], exp_g[i]); end
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL mask_select got %0d odd-select cycles exp 0", bad); end
    checks++; if (obs_data_q.size() !== exp_data_q.size()) begin errors++; $display("FAIL mask_count got %0d exp %0d", obs_data_q.size(), exp_data_q.size()); end
    for (int i = 0; i < obs_data_q.size() && i < exp_data_q.size(); i++) begin
      checks++; if (obs_data_q[i] !== exp_data_q[i] || obs_sink_q[i] !== exp_sink_q[i]) begin
        errors++; $display("FAIL mask_beat[%0d] got %0h@%0d exp %0h@%0d", i, obs_data_q[i], obs_sink_q[i], exp_data_q[i], exp_sink_q[i]);
      end
    end
  endtask

  task automatic test_last();
    int n;
    int exp_s[6] = '{0, 0, 1, 1, 1, 1};
    do_reset();
    en = 1'b1; sink_en = 4'b1111; out_ready = 4'b1111;
    n = 0;
    for (int c = 0; c < 60 && obs_data_q.size() < 6; c++) begin
      in_valid = (n < 6);
      in_data  = DW'(8'h30 + n);
      in_last  = (n == 1);
      tick();
      if (acc_flag) n++;
    end
    in_valid = 1'b0; in_last = 1'b0;
    checks++; if (obs_data_q.size() !== 6) begin errors++; $display("FAIL last_count got %0d exp 6", obs_data_q.size()); end
    for (int i = 0; i < 6 && i < obs_data_q.size(); i++) begin
      checks++; if (obs_sink_q[i] !== exp_s[i] || obs_data_q[i] !== 8'h30 + i) begin
        errors++; $display("FAIL last_beat[%0d] got %0h@%0d exp %0h@%0d", i, obs_data_q[i], obs_sink_q[i], 8'h30 + i, exp_s[i]);
      end
    end
    checks++; if (grant_obs_q.size() !== 2) begin errors++; $display("FAIL last_grants got %0d exp 2", grant_obs_q.size()); end
  endtask

  task automatic test_stall();
    int n;
    int stall_left;
    bit stalled;
    do_reset();
    en = 1'b1; sink_en = 4'b1111; out_ready = 4'b1111; in_last = 1'b0;
    n = 0; stall_left = 0; stalled = 0;
    for (int c = 0; c < 60 && obs_data_q.size() < 8; c++) begin
      in_valid  = (n < 8);
      in_data   = DW'(8'h10 + n);
      out_ready = (stall_left > 0) ? 4'b1110 : 4'b1111;
      tick();
      if (stall_left > 0) begin
        checks++; if (s_in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready[%0d] got %b exp 0", stall_left, s_in_ready); end
        checks++; if (s_out_valid !== 4'b0001) begin errors++; $display("FAIL stall_out_valid[%0d] got %b exp 0001", stall_left, s_out_valid); end
        checks++; if (s_out_data !== 8'h11) begin errors++; $display("FAIL stall_out_data[%0d] got %h exp 11", stall_left, s_out_data); end
        stall_left--;
      end
      if (acc_flag) begin
        n++;
        if (n == 2 && !stalled) begin stall_left = 3; stalled = 1; end
      end
    end
    in_valid = 1'b0; out_ready = 4'b1111;
    checks++; if (obs_data_q.size() !== 8) begin errors++; $display("FAIL stall_count got %0d exp 8", obs_data_q.size()); end
    for (int i = 0; i < 8 && i < obs_data_q.size(); i++) begin
      checks++; if (obs_data_q[i] !== 8'h10 + i || obs_sink_q[i] !== (i < 4 ? 0 : 1)) begin
        errors++; $display("FAIL stall_beat[%0d] got %0h@%0d exp %0h@%0d", i, obs_data_q[i], obs_sink_q[i], 8'h10 + i, (i < 4 ? 0 : 1));
      end
    end
  endtask

  task automatic test_en_drop();
    int n;
    int busy_after;
    bit done_before;
    do_reset();
    en = 1'b1; sink_en = 4'b1111; out_ready = 4'b1111; in_last = 1'b0;
    n = 0; busy_after = 0;
    for (int c = 0; c < 30; c++) begin
      in_valid = 1'b1; in_data = DW'(8'h40 + n);
      done_before = (obs_data_q.size() >= 4);
      tick();
      if (done_before && s_busy) busy_after++;
      if (acc_flag) begin n++; if (n == 1) en = 1'b0; end
    end
    checks++; if (n !== 4) begin errors++; $display("FAIL endrop_accepts got %0d exp 4", n); end
    checks++; if (obs_sink_q.size() !== 4 || obs_sink_q[0] !== 0 || obs_sink_q[3] !== 0) begin
      errors++; $display("FAIL endrop_sink got n=%0d exp 4 beats to sink 0", obs_sink_q.size());
    end
    checks++; if (busy_after !== 0) begin errors++; $display("FAIL endrop_idle got %0d busy cycles exp 0", busy_after); end

    clear_queues();
    en = 1'b1; sink_en = 4'b1111;
    n = 0; busy_after = 0;
    for (int c = 0; c < 30; c++) begin
      in_valid = 1'b1; in_data = DW'(8'h48 + n);
      done_before = (obs_data_q.size() >= 4);
      tick();
      if (done_before && s_busy) busy_after++;
      if (acc_flag) begin n++; if (n == 1) sink_en = 4'b0000; end
    end
    checks++; if (n !== 4) begin errors++; $display("FAIL maskdrop_accepts got %0d exp 4", n); end
    checks++; if (obs_sink_q.size() !== 4 || obs_sink_q[0] !== 1 || obs_sink_q[3] !== 1) begin
      errors++; $display("FAIL maskdrop_sink got n=%0d exp 4 beats to sink 1", obs_sink_q.size());
    end
    checks++; if (busy_after !== 0) begin errors++; $display("FAIL maskdrop_idle got %0d busy cycles exp 0", busy_after); end

    do_reset();
    en = 1'b1; sink_en = 4'b0000; out_ready = 4'b1111; in_valid = 1'b1;
    repeat (20) tick();
    in_valid = 1'b0;
    checks++; if (grant_obs_q.size() !== 0 || acc_cyc_q.size() !== 0) begin
      errors++; $display("FAIL nomask_grant got grants=%0d accepts=%0d exp 0 0", grant_obs_q.size(), acc_cyc_q.size());
    end
  endtask

  task automatic test_random();
    do_reset();
    en = 1'b1; in_valid = 1'b0; in_last = 1'b0;
    for (int seg = 0; seg < 4; seg++) begin
      sink_en = (seg == 0) ? 4'b1111 : 4'($urandom_range(1, 15));
      for (int c = 0; c < 200; c++) begin
        if (!in_valid && $urandom_range(0, 3) != 0) begin
          in_valid = 1'b1;
          in_data  = DW'($urandom);
          in_last  = ($urandom_range(0, 4) == 0);
        end
        out_ready = 4'($urandom) | 4'($urandom);
        tick();
        if (acc_flag) in_valid = 1'b0;
      end
      for (int w = 0; w < 50 && in_valid; w++) begin
        out_ready = 4'b1111;
        tick();
        if (acc_flag) in_valid = 1'b0;
      end
      in_valid = 1'b0; in_last = 1'b0;
    end
    out_ready = 4'b1111;
    repeat (10) tick();
    checks++; if (exp_data_q.size() < 100) begin errors++; $display("FAIL rand_progress got %0d beats exp >=100", exp_data_q.size()); end
    checks++; if (obs_data_q.size() !== exp_data_q.size()) begin errors++; $display("FAIL rand_count got %0d exp %0d", obs_data_q.size(), exp_data_q.size()); end
    for (int i = 0; i < obs_data_q.size() && i < exp_data_q.size(); i++) begin
      checks++; if (obs_data_q[i] !== exp_data_q[i] || obs_sink_q[i] !== exp_sink_q[i]) begin
        errors++; $display("FAIL rand_beat[%0d] got %0h@%0d exp %0h@%0d", i, obs_data_q[i], obs_sink_q[i], exp_data_q[i], exp_sink_q[i]);
      end
    end
    checks++; if (sel_err !== 0) begin errors++; $display("FAIL rand_select got %0d bad cycles exp 0", sel_err); end
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    en = 1'b1; sink_en = 4'b1111; out_ready = 4'b1111; in_last = 1'b0;
    n = 0;
    for (int c = 0; c < 40 && n < 6; c++) begin
      in_valid = 1'b1; in_data = DW'(8'h50 + n);
      tick();
      if (acc_flag) n++;
    end
    #1;
    checks++; if (out_valid !== 4'b0010) begin errors++; $display("FAIL rstmid_pre got %b exp 0010", out_valid); end
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk); #1;
    checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL rstmid_out_valid got %b exp 0000", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rstmid_in_ready got %b exp 0", in_ready); end
    checks++; if ({s0, s1} !== 2'b00) begin errors++; $display("FAIL rstmid_sel got %b exp 00", {s0, s1}); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b exp 0", busy); end
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    clear_model();
    n = 0;
    for (int c = 0; c < 30 && obs_data_q.size() < 4; c++) begin
      in_valid = (n < 4); in_data = DW'(8'h60 + n);
      tick();
      if (acc_flag) n++;
    end
    in_valid = 1'b0;
    checks++; if (grant_obs_q.size() < 1 || grant_obs_q[0] !== 0) begin
      errors++; $display("FAIL rstmid_first_grant got %0d exp 0", (grant_obs_q.size() > 0) ? grant_obs_q[0] : -1);
    end
    checks++; if (obs_data_q.size() !== 4) begin errors++; $display("FAIL rstmid_count got %0d exp 4", obs_data_q.size()); end
    for (int i = 0; i < 4 && i < obs_data_q.size(); i++) begin
      checks++; if (obs_data_q[i] !== 8'h60 + i || obs_sink_q[i] !== 0) begin
        errors++; $display("FAIL rstmid_beat[%0d] got %0h@%0d exp %0h@0", i, obs_data_q[i], obs_sink_q[i], 8'h60 + i);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; sink_en = 4'b0000; in_valid = 1'b0;
    in_data = '0; in_last = 1'b0; out_ready = 4'b0000;
    clear_model();
    test_reset();
    test_basic();
    test_mask();
    test_last();
    test_stall();
    test_en_drop();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Overall time limit in case the bench itself stalls.
  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule
